// File: rtl/framebuffer_stream_sink.sv
// Unpacks a wide framebuffer AXI-stream into single pixels with (x,y) coordinates and frame/tlast status pulses.
// Optional build macro FRAMEBUFFER_STREAM_SINK_BYTE_SWAP_EN swaps the two bytes of every output pixel.
module framebuffer_stream_sink #(
   parameter int FRAMEBUFFER_STREAM_WIDTH = 64,
   parameter int PIXEL_WIDTH              = 16,
   parameter int X_RESOLUTION             = 640,
   parameter int Y_RESOLUTION             = 480
) (
   input  logic                                aclk,
   input  logic                                reset,
   input  logic                                s_framebuffer_axis_tvalid,
   output logic                                s_framebuffer_axis_tready,
   input  logic                                s_framebuffer_axis_tlast,
   input  logic [FRAMEBUFFER_STREAM_WIDTH-1:0] s_framebuffer_axis_tdata,
   output logic                                m_pixel_valid,
   input  logic                                m_pixel_ready,
   output logic [PIXEL_WIDTH-1:0]              m_pixel_data,
   output logic [$clog2(X_RESOLUTION)-1:0]     m_pixel_x,
   output logic [$clog2(Y_RESOLUTION)-1:0]     m_pixel_y,
   output logic                                frame_done,
   output logic                                tlast_error
);

   localparam int PPB    = FRAMEBUFFER_STREAM_WIDTH / PIXEL_WIDTH;
   localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 1;
   localparam int X_W    = $clog2(X_RESOLUTION);
   localparam int Y_W    = $clog2(Y_RESOLUTION);

   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPB - 1);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(X_RESOLUTION - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_RESOLUTION - 1);

   logic [FRAMEBUFFER_STREAM_WIDTH-1:0] beat_data;
   logic                                beat_full;
   logic                                beat_last;
   logic [LANE_W-1:0]                   lane;
   logic [PIXEL_WIDTH-1:0]              lane_pixel;
   logic                                pixel_xfer;
   logic                                beat_accept;
   logic                                lane_is_last;
   logic                                at_frame_end;
   logic                                resync;

   always_comb begin
      lane_pixel = '0;
      for (int i = 0; i < PPB; i++) begin
         if (lane == LANE_W'(i)) lane_pixel = beat_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

`ifdef FRAMEBUFFER_STREAM_SINK_BYTE_SWAP_EN
   assign m_pixel_data = {lane_pixel[7:0], lane_pixel[PIXEL_WIDTH-1:8]};
`else
   assign m_pixel_data = lane_pixel;
`endif

   assign m_pixel_valid = beat_full && !reset;
   assign pixel_xfer    = m_pixel_valid && m_pixel_ready;
   assign lane_is_last  = (lane == LANE_LAST);

   // Refill in the same cycle the final lane leaves, so a full-rate stream has no bubble.
   assign s_framebuffer_axis_tready = !reset && (!beat_full || (pixel_xfer && lane_is_last));
   assign beat_accept               = s_framebuffer_axis_tvalid && s_framebuffer_axis_tready;

   assign at_frame_end = (m_pixel_x == X_LAST) && (m_pixel_y == Y_LAST);
   assign frame_done   = pixel_xfer && at_frame_end;
   assign tlast_error  = pixel_xfer && lane_is_last && (beat_last != at_frame_end);
   assign resync       = pixel_xfer && lane_is_last && beat_last && !at_frame_end;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (reset) begin
         // NOTE: the beat register is cleared too, so m_pixel_data reads zero while held in reset.
         beat_data <= '0;
         beat_full <= 1'b0;
         beat_last <= 1'b0;
         lane      <= '0;
         m_pixel_x <= '0;
         m_pixel_y <= '0;
      end else begin
         if (beat_accept) begin
            beat_data <= s_framebuffer_axis_tdata;
            beat_last <= s_framebuffer_axis_tlast;
            beat_full <= 1'b1;
         end else if (pixel_xfer && lane_is_last) begin
            beat_full <= 1'b0;
         end

         if (pixel_xfer) begin
            lane <= lane_is_last ? '0 : lane + LANE_W'(1);
            if (resync) begin
               m_pixel_x <= '0;
               m_pixel_y <= '0;
            end else if (m_pixel_x == X_LAST) begin
               m_pixel_x <= '0;
               m_pixel_y <= (m_pixel_y == Y_LAST) ? '0 : m_pixel_y + Y_W'(1);
            end else begin
               m_pixel_x <= m_pixel_x + X_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_stream_sink.sv
// Randomized scoreboard bench for framebuffer_stream_sink at 8x2 pixels, 64-bit beats (4 beats per frame).
// Honors FRAMEBUFFER_STREAM_SINK_BYTE_SWAP_EN for the expected pixel values.
module tb_framebuffer_stream_sink;

   localparam int W   = 64;
   localparam int PW  = 16;
   localparam int XR  = 8;
   localparam int YR  = 2;
   localparam int PPB = W / PW;

   logic          aclk = 1'b0;
   logic          reset;
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic [W-1:0]  tdata;
   logic          m_pixel_valid;
   logic          m_pixel_ready;
   logic [PW-1:0] m_pixel_data;
   logic [2:0]    m_pixel_x;
   logic [0:0]    m_pixel_y;
   logic          frame_done;
   logic          tlast_error;

   framebuffer_stream_sink #(
      .FRAMEBUFFER_STREAM_WIDTH(W),
      .PIXEL_WIDTH(PW),
      .X_RESOLUTION(XR),
      .Y_RESOLUTION(YR)
   ) dut (
      .aclk(aclk),
      .reset(reset),
      .s_framebuffer_axis_tvalid(tvalid),
      .s_framebuffer_axis_tready(tready),
      .s_framebuffer_axis_tlast(tlast),
      .s_framebuffer_axis_tdata(tdata),
      .m_pixel_valid(m_pixel_valid),
      .m_pixel_ready(m_pixel_ready),
      .m_pixel_data(m_pixel_data),
      .m_pixel_x(m_pixel_x),
      .m_pixel_y(m_pixel_y),
      .frame_done(frame_done),
      .tlast_error(tlast_error)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [PW-1:0] data;
      int            x;
      int            y;
      bit            fd;
      bit            err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   xfer_cnt = 0;
   int   last_acc_cyc = 0;
   int   last_fd_cyc = 0;
   int   pos = 0;
   int   rmode = 0;
   bit   mon_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] out_pixel(logic [PW-1:0] p);
`ifdef FRAMEBUFFER_STREAM_SINK_BYTE_SWAP_EN
      return {p[7:0], p[15:8]};
`else
      return p;
`endif
   endfunction

   // Reference: pos is the frame pixel index of the next beat's first lane.
   task automatic model_beat(logic [W-1:0] d, bit last);
      bit at_end = (pos + PPB == XR * YR);
      for (int i = 0; i < PPB; i++) begin
         exp_t e;
         int   p = pos + i;
         e.data = out_pixel(d[i*PW +: PW]);
         e.x    = p % XR;
         e.y    = p / XR;
         e.fd   = (i == PPB - 1) && at_end;
         e.err  = (i == PPB - 1) && (last != at_end);
         sb.push_back(e);
      end
      pos = (last && !at_end) ? 0 : (pos + PPB) % (XR * YR);
   endtask

   always @(posedge aclk) cyc++;

   always @(posedge aclk) begin
      #1;
      case (rmode)
         0:       m_pixel_ready = 1'b1;
         1:       m_pixel_ready = ~m_pixel_ready;
         default: m_pixel_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge aclk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (m_pixel_valid && m_pixel_ready) begin
            xfer_cnt++;
            check("pixel_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("pixel_data", 32'(m_pixel_data), 32'(e.data));
               check("pixel_x", 32'(m_pixel_x), 32'(e.x));
               check("pixel_y", 32'(m_pixel_y), 32'(e.y));
               check("frame_done", 32'(frame_done), 32'(e.fd));
               check("tlast_error", 32'(tlast_error), 32'(e.err));
               if (frame_done) last_fd_cyc = cyc;
            end
         end else begin
            check("idle_pulses", 32'({frame_done, tlast_error}), 32'd0);
         end
      end
   end

   task automatic send_beat(logic [W-1:0] d, bit last);
      int waited = 0;
      tvalid = 1'b1;
      tdata  = d;
      tlast  = last;
      @(negedge aclk);
      while (!tready && waited < 200) begin
         @(negedge aclk);
         waited++;
      end
      if (!tready) begin
         check("tready_timeout", 32'(tready), 32'd1);
         tvalid = 1'b0;
         return;
      end
      model_beat(d, last);
      last_acc_cyc = cyc;
      @(posedge aclk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   function automatic logic [W-1:0] seq_beat(int b);
      return {16'(4*b + 4), 16'(4*b + 3), 16'(4*b + 2), 16'(4*b + 1)};
   endfunction

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 400) begin
         @(negedge aclk);
         guard++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_tready", 32'(tready), 32'd0);
      check("rst_valid", 32'(m_pixel_valid), 32'd0);
      check("rst_data", 32'(m_pixel_data), 32'd0);
      check("rst_x", 32'(m_pixel_x), 32'd0);
      check("rst_y", 32'(m_pixel_y), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_tlast_error", 32'(tlast_error), 32'd0);
   endtask

   initial begin
      int t0;
      int base;
      int guard;
      reset = 1'b1;
      tvalid = 1'b0;
      tlast = 1'b0;
      tdata = '0;
      m_pixel_ready = 1'b0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_reset_outputs();
      mon_en = 1'b1;
      @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      check("tready_after_reset", 32'(tready), 32'd1);
      @(posedge aclk);
      #1;

      // Full rate: one beat per four cycles, frame_done 16 cycles after first acceptance.
      rmode = 0;
      for (int b = 0; b < 4; b++) begin
         send_beat(seq_beat(b), b == 3);
         if (b == 0) t0 = last_acc_cyc;
      end
      drain();
      check("full_rate_cycles", 32'(last_fd_cyc - t0), 32'd16);

      // Ready toggling every cycle.
      rmode = 1;
      for (int b = 0; b < 4; b++) send_beat(seq_beat(b), b == 3);
      drain();

      // Early tlast on beat 2 then a resynced frame; then missing tlast on beat 4.
      rmode = 0;
      for (int b = 0; b < 2; b++) send_beat(seq_beat(b), b == 1);
      for (int b = 0; b < 4; b++) send_beat(seq_beat(b + 4), b == 3);
      for (int b = 0; b < 4; b++) send_beat(seq_beat(b), 1'b0);
      send_beat({16'h4444, 16'h3333, 16'h2222, 16'h1234}, 1'b0);
      drain();

      // Reset after two pixels of the second beat.
      base = xfer_cnt;
      send_beat(seq_beat(0), 1'b0);
      send_beat(seq_beat(1), 1'b0);
      guard = 0;
      while (xfer_cnt < base + 6 && guard < 100) begin
         @(negedge aclk);
         #1;
         guard++;
      end
      check("reset_point", 32'(xfer_cnt - base), 32'd6);
      @(posedge aclk);
      #1;
      reset = 1'b1;
      sb.delete();
      pos = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check_reset_outputs();
      @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      check("tready_after_reset2", 32'(tready), 32'd1);
      @(posedge aclk);
      #1;
      send_beat({16'h0004, 16'h0003, 16'h0002, 16'h1234}, 1'b0);
      drain();

      // Randomized traffic with occasional tlast misplacement and input gaps.
      rmode = 2;
      for (int n = 0; n < 150; n++) begin
         bit at_end = (pos + PPB == XR * YR);
         bit last   = ($urandom_range(0, 9) == 0) ? !at_end : at_end;
         send_beat({$urandom, $urandom}, last);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge aclk);
            #1;
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
